// File: rtl/gate_id_pkg.sv
// Shared types for the gate identifier: FSM states, gate codes and the
// truth-table signatures (bit index = {A,B}) of each recognised gate.
package gate_id_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    GATE_AND     = 3'd0,
    GATE_OR      = 3'd1,
    GATE_NOT_A   = 3'd2,
    GATE_NAND    = 3'd3,
    GATE_NOR     = 3'd4,
    GATE_XOR     = 3'd5,
    GATE_XNOR    = 3'd6,
    GATE_UNKNOWN = 3'd7
  } gate_code_t;

  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_OR    = 4'b1110;
  localparam logic [3:0] TT_NOT_A = 4'b0011;
  localparam logic [3:0] TT_NAND  = 4'b0111;
  localparam logic [3:0] TT_NOR   = 4'b0001;
  localparam logic [3:0] TT_XOR   = 4'b0110;
  localparam logic [3:0] TT_XNOR  = 4'b1001;

endpackage

// File: rtl/gate_id_classifier.sv
// Maps a captured 4-entry truth table to a gate code; purely combinational.
// Any pattern that is not one of the seven known signatures reads as UNKNOWN.
module gate_classifier
  import gate_id_pkg::*;
(
  input  logic [3:0] truth_table,
  output gate_code_t gate_code
);

  always_comb begin
    gate_code = GATE_UNKNOWN;
    case (truth_table)
      TT_AND:   gate_code = GATE_AND;
      TT_OR:    gate_code = GATE_OR;
      TT_NOT_A: gate_code = GATE_NOT_A;
      TT_NAND:  gate_code = GATE_NAND;
      TT_NOR:   gate_code = GATE_NOR;
      TT_XOR:   gate_code = GATE_XOR;
      TT_XNOR:  gate_code = GATE_XNOR;
      default:  gate_code = GATE_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/gate_identifier.sv
// Sweeps A/B over 00,01,10,11 and classifies the external gate's response.
// Result valid 4*(SETTLE_CYCLES+1) cycles after start; start ignored mid-sweep.
module gate_identifier
  import gate_id_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_y,
  output logic       A_drv,
  output logic       B_drv,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] gate_code,
  output logic       known
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] vec;
  logic [3:0] cnt;
  logic [3:0] tt_cap;
  gate_code_t gc_cls;
  gate_code_t gc_q;
  logic       in_sweep;

  // Table as it will look after this cycle's capture, so the final code
  // can be registered on the same edge that enters DONE.
  always_comb begin
    tt_cap      = truth_table;
    tt_cap[vec] = dut_y;
  end

  gate_classifier u_classifier (
    .truth_table (tt_cap),
    .gate_code   (gc_cls)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (cnt == CNT_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (vec == 2'd3) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec         <= 2'd0;
      cnt         <= 4'd0;
      truth_table <= 4'd0;
      gc_q        <= GATE_UNKNOWN;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec         <= 2'd0;
            cnt         <= 4'd0;
            truth_table <= 4'd0;
            gc_q        <= GATE_UNKNOWN;
          end
        end
        SETTLE: cnt <= cnt + 4'd1;
        CAPTURE: begin
          truth_table <= tt_cap;
          if (vec == 2'd3) begin
            gc_q <= gc_cls;
          end else begin
            vec <= vec + 2'd1;
            cnt <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_sweep  = (state == SETTLE) || (state == CAPTURE);
  assign busy      = in_sweep;
  assign A_drv     = in_sweep & vec[1];
  assign B_drv     = in_sweep & vec[0];
  assign done      = (state == DONE);
  assign gate_code = gc_q;
  assign known     = (gc_q != GATE_UNKNOWN);

endmodule

// File: tb/tb_gate_identifier.sv
// Directed bench: behavioural gate models feed dut_y from A_drv/B_drv.
module tb_gate_identifier;

  localparam int P = 3;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] mt;
  logic       glitch;
  logic       dut_y;
  logic       A_drv, B_drv, busy, done, known;
  logic [3:0] truth_table;
  logic [2:0] gate_code;

  logic       start2, dut_y2, A2, B2, busy2, done2, known2;
  logic [3:0] tt2;
  logic [2:0] gc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dut_y  = mt[{A_drv, B_drv}] ^ glitch;
  assign dut_y2 = A2 & B2;

  gate_identifier #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_y(dut_y),
    .A_drv(A_drv), .B_drv(B_drv), .busy(busy), .done(done),
    .truth_table(truth_table), .gate_code(gate_code), .known(known)
  );

  gate_identifier #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start2), .dut_y(dut_y2),
    .A_drv(A2), .B_drv(B2), .busy(busy2), .done(done2),
    .truth_table(tt2), .gate_code(gc2), .known(known2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ab"},    32'({A_drv, B_drv}), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_tt"},    32'(truth_table), 32'd0);
    check({tag, "_gc"},    32'(gate_code), 32'd7);
    check({tag, "_known"}, 32'(known), 32'd0);
  endtask

  task automatic run_sweep(input string tag, input logic [3:0] model,
                           input logic [3:0] exp_tt, input logic [2:0] exp_gc,
                           input logic exp_known, input bit repulse, input bit glitchy);
    int first;
    int ndone;
    first = -1;
    ndone = 0;
    mt    = model;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_gc_cleared"}, 32'(gate_code), 32'd7);
    check({tag, "_known_cleared"}, 32'(known), 32'd0);
    check({tag, "_tt_cleared"}, 32'(truth_table), 32'd0);
    for (int k = 0; k <= 30; k++) begin
      if (k < 4 * P) begin
        check({tag, "_ab_seq"}, 32'({A_drv, B_drv}), 32'(k / P));
        check({tag, "_busy_sweep"}, 32'(busy), 32'd1);
      end
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = k;
          check({tag, "_ab_in_done"}, 32'({A_drv, B_drv}), 32'd0);
          check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
          check({tag, "_gc_at_done"}, 32'(gate_code), 32'(exp_gc));
        end
      end
      if (first >= 0 && k == first + 1) begin
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_after"}, 32'(done), 32'd0);
      end
      start  = repulse && (k == 3 || k == 7 || (first >= 0 && k == first));
      glitch = glitchy && (k < 4 * P) && ((k % P) != P - 1);
      tick();
    end
    start  = 1'b0;
    glitch = 1'b0;
    check({tag, "_done_cycle"}, 32'(first), 32'd12);
    check({tag, "_done_count"}, 32'(ndone), 32'd1);
    check({tag, "_tt"}, 32'(truth_table), 32'(exp_tt));
    check({tag, "_gc"}, 32'(gate_code), 32'(exp_gc));
    check({tag, "_known"}, 32'(known), 32'(exp_known));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    int first;
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    mt     = 4'b0000;
    glitch = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    check("reset_gc2", 32'(gc2), 32'd7);
    check("reset_busy2", 32'(busy2), 32'd0);
    rst = 1'b0;
    tick();

    run_sweep("nand", 4'b0111, 4'b0111, 3'd3, 1'b1, 1'b0, 1'b0);
    run_sweep("xor",  4'b0110, 4'b0110, 3'd5, 1'b1, 1'b1, 1'b0);
    run_sweep("xnor", 4'b1001, 4'b1001, 3'd6, 1'b1, 1'b0, 1'b1);
    run_sweep("ones", 4'b1111, 4'b1111, 3'd7, 1'b0, 1'b0, 1'b0);
    run_sweep("nor",  4'b0001, 4'b0001, 3'd4, 1'b1, 1'b0, 1'b0);
    run_sweep("nota", 4'b0011, 4'b0011, 3'd2, 1'b1, 1'b0, 1'b0);

    // Abort a sweep with reset at cycle 5.
    mt    = 4'b1110;
    ndone = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    rst = 1'b1;
    tick();
    check_idle_outputs("midrst");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    // Reset and start on the same edge.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'd0);
    tick();
    check("rst_prio_busy2", 32'(busy), 32'd0);

    run_sweep("or", 4'b1110, 4'b1110, 3'd1, 1'b1, 1'b0, 1'b0);

    // SETTLE_CYCLES=1 instance with an AND gate.
    first  = -1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (done2 === 1'b1 && first < 0) first = k;
      tick();
    end
    check("and1_done_cycle", 32'(first), 32'd8);
    check("and1_tt", 32'(tt2), 32'b1000);
    check("and1_gc", 32'(gc2), 32'd0);
    check("and1_known", 32'(known2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
